memory: RTL and testbench

MEMORY -- requirements
Module: memory

---
 rtl/memory.sv | 65 ++++++
 tb/tb_memory.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/memory.sv
// Purpose: DEPTH x WIDTH register-file memory with sync clear; optional write-first bypass via MEMORY_WRITE_BYPASS_EN.
// Latency: 1 cycle from read_en_i to read_data_o/read_valid_o; writes visible to reads from the next cycle.
// Backpressure: none, one read and one write accepted every cycle.
module memory #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             read_en_i,
  input  logic [AW-1:0]    read_pos_i,
  output logic [WIDTH-1:0] read_data_o,
  output logic             read_valid_o,
  input  logic             write_en_i,
  input  logic [AW-1:0]    write_pos_i,
  input  logic [WIDTH-1:0] write_data_i
);

  localparam logic [AW:0] DEPTH_L = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] read_data_q, read_data_d;
  logic             read_valid_q, read_valid_d;
  logic             rd_in_range, wr_in_range;

  // Addresses past DEPTH only exist when DEPTH is not a power of two.
  assign rd_in_range = ({1'b0, read_pos_i} < DEPTH_L);
  assign wr_in_range = ({1'b0, write_pos_i} < DEPTH_L);

  always_comb begin
    mem_d        = mem_q;
    read_data_d  = read_data_q;
    read_valid_d = 1'b0;
    if (read_en_i) begin
      read_valid_d = 1'b1;
      read_data_d  = rd_in_range ? mem_q[read_pos_i] : '0;
`ifdef MEMORY_WRITE_BYPASS_EN
      if (write_en_i && wr_in_range && (write_pos_i == read_pos_i)) begin
        read_data_d = write_data_i;
      end
`endif
    end
    if (write_en_i && wr_in_range) begin
      mem_d[write_pos_i] = write_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q        <= '{default: '0};
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
    end else begin
      mem_q        <= mem_d;
      read_data_q  <= read_data_d;
      read_valid_q <= read_valid_d;
    end
  end

  assign read_data_o  = read_data_q;
  assign read_valid_o = read_valid_q;

endmodule

// File: tb/tb_memory.sv
// Scoreboard bench for memory: stimulus pushes model expectations, a negedge monitor pops and compares.
module tb_memory;
  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
  localparam int AW = $clog2(DEPTH);
`ifdef MEMORY_WRITE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             read_en;
  logic [AW-1:0]    read_pos;
  logic [WIDTH-1:0] read_data;
  logic             read_valid;
  logic             write_en;
  logic [AW-1:0]    write_pos;
  logic [WIDTH-1:0] write_data;

  always #5 clk = ~clk;

  memory #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .read_en_i   (read_en),
    .read_pos_i  (read_pos),
    .read_data_o (read_data),
    .read_valid_o(read_valid),
    .write_en_i  (write_en),
    .write_pos_i (write_pos),
    .write_data_i(write_data)
  );

  typedef struct {
    logic             vld;
    logic [WIDTH-1:0] dat;
    string            tag;
  } exp_t;

  exp_t             exp_q[$];
  logic [WIDTH-1:0] model_mem [DEPTH];
  logic [WIDTH-1:0] model_last;
  int               tests = 0;
  int               fails = 0;
  string            cur_tag = "init";

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // Behavioural model: evaluated on the edge with the inputs that were presented to it.
  task automatic cycle();
    exp_t e;
    @(posedge clk);
    e.tag = cur_tag;
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
      model_last = '0;
      e.vld = 1'b0;
      e.dat = '0;
    end else begin
      e.vld = read_en;
      if (read_en) begin
        if (int'(read_pos) >= DEPTH) e.dat = '0;
        else if (BYPASS && write_en && write_pos == read_pos) e.dat = write_data;
        else e.dat = model_mem[read_pos];
        model_last = e.dat;
      end else begin
        e.dat = model_last;
      end
      if (write_en && int'(write_pos) < DEPTH) model_mem[write_pos] = write_data;
    end
    exp_q.push_back(e);
    #1;
  endtask

  task automatic op(input logic r, input logic ren, input int rpos,
                    input logic wen, input int wpos, input logic [WIDTH-1:0] wdat);
    rst        = r;
    read_en    = ren;
    read_pos   = AW'(rpos);
    write_en   = wen;
    write_pos  = AW'(wpos);
    write_data = wdat;
    cycle();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({e.tag, " valid"}, WIDTH'(read_valid), WIDTH'(e.vld));
      check({e.tag, " data"}, read_data, e.dat);
    end
  end

  initial begin
    cur_tag = "reset";
    op(1, 1, 5, 1, 5, 32'h1234);
    op(1, 0, 0, 0, 0, 0);

    cur_tag = "write_read_69";
    op(0, 0, 0, 1, 5, 69);
    op(0, 0, 0, 0, 0, 0);
    op(0, 1, 5, 0, 0, 0);
    op(0, 0, 0, 0, 0, 0);

    cur_tag = "write_disabled";
    op(0, 0, 0, 0, 5, 99);
    op(0, 1, 5, 0, 0, 0);

    cur_tag = "reset_clears";
    op(0, 0, 0, 1, 3, 32'hDEADBEEF);
    op(1, 0, 0, 0, 0, 0);
    op(0, 1, 3, 0, 0, 0);
    op(0, 0, 0, 0, 0, 0);

    cur_tag = "back_to_back";
    op(0, 0, 0, 1, 0, 1);
    op(0, 0, 0, 1, 15, 2);
    op(0, 1, 0, 0, 0, 0);
    op(0, 1, 15, 0, 0, 0);
    op(0, 1, 0, 0, 0, 0);
    op(0, 0, 0, 0, 0, 0);
    op(0, 0, 0, 0, 0, 0);

    cur_tag = "same_addr_rw";
    op(0, 0, 0, 1, 7, 10);
    op(0, 0, 0, 0, 0, 0);
    op(0, 1, 7, 1, 7, 20);
    op(0, 1, 7, 0, 0, 0);
    op(0, 1, 2, 1, 9, 32'hA5A5);
    op(0, 1, 9, 0, 0, 0);

    cur_tag = "reset_aborts_read";
    op(0, 1, 7, 0, 0, 0);
    op(1, 1, 7, 1, 7, 5);
    op(0, 1, 7, 0, 0, 0);

    cur_tag = "random";
    for (int n = 0; n < 600; n++) begin
      int rp, wp;
      rp = $urandom_range(0, DEPTH - 1);
      wp = ($urandom_range(0, 3) == 0) ? rp : $urandom_range(0, DEPTH - 1);
      op(($urandom_range(0, 49) == 0), $urandom_range(0, 1) == 1, rp,
         $urandom_range(0, 1) == 1, wp, $urandom);
    end

    cur_tag = "drain";
    op(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
